// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {GNT_CPU, GNT_DMA} grant_t;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/starve_ctr.sv
// Saturating count of consecutive denied DMA cycles; at_max requests a forced grant.
module starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [STARVE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

  assign at_max = (cnt == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core (priority) and a DMA requester,
// with a bounded-starvation forced DMA grant that stalls the core for one cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_web,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  input  logic                dma_valid,
  input  logic                dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  input  logic [DATA_W/8-1:0] dma_web,
  output logic                dma_ready,
  output logic [DATA_W-1:0]   dma_rdata,
  output logic                dma_rvalid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_web,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  grant_t grant;
  logic   at_max;
  logic   force_dma;
  logic   ctr_clr;
  logic   ctr_inc;

  starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (ctr_clr),
    .inc    (ctr_inc),
    .at_max (at_max)
  );

  // Grant decision; everything is suppressed while reset is held.
  always_comb begin
    force_dma = 1'b0;
    grant     = GNT_CPU;
    if (reset) begin
      force_dma = dma_valid && cpu_req && at_max;
      if (dma_valid && (!cpu_req || force_dma)) begin
        grant = GNT_DMA;
      end
    end
  end

  assign ctr_clr = (grant == GNT_DMA) || !dma_valid;
  assign ctr_inc = dma_valid && cpu_req && !force_dma;

  // Memory port mux; idle defaults point at the core address with no write.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_web   = '0;
    dma_ready = 1'b0;
    cpu_stall = 1'b0;
    if (reset) begin
      cpu_stall = force_dma;
      if (grant == GNT_DMA) begin
        dma_ready = 1'b1;
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_web   = dma_web;
      end else if (cpu_req && cpu_we) begin
        mem_we  = 1'b1;
        mem_web = cpu_web;
      end
    end
  end

  assign cpu_rdata = mem_rdata;

  // DMA read data is captured at the edge ending the accepting cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_ready && !dma_we;
      if (dma_ready && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

  logic unused_be;
  assign unused_be = (BE_W == 0);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the single-cycle RISC-V core and a DMA/loader requester. It sits between `riscvsingle`/`dmem` and the DMA engine. The core has priority, and a bounded-starvation counter forces a DMA grant, stalling the core for one cycle, after `STARVE_MAX` consecutive denied DMA cycles. Memory reads are combinational, so core loads complete in the same cycle; DMA read data is returned registered.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte enables
- `STARVE_MAX`, 4, consecutive denied DMA cycles before a forced DMA grant (1..15)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `cpu_req`  in  1  core issues a load or store this cycle
- `cpu_we`  in  1  core store
- `cpu_addr`  in  ADDR_W  core address
- `cpu_wdata`  in  DATA_W  core store data
- `cpu_web`  in  DATA_W/8  core byte write enables
- `cpu_rdata`  out  DATA_W  `mem_rdata` pass-through
- `cpu_stall`  out  1  core must hold PC and request this cycle
- `dma_valid`  in  1  DMA request pending
- `dma_we`, `dma_addr`, `dma_wdata`, `dma_web`  in  1/ADDR_W/DATA_W/DATA_W/8  DMA request fields
- `dma_ready`  out  1  DMA request accepted this cycle
- `dma_rdata`  out  DATA_W  registered DMA read data
- `dma_rvalid`  out  1  `dma_rdata` valid (1-cycle pulse)
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_web`  out  1/ADDR_W/DATA_W/DATA_W/8  to `dmem`
- `mem_rdata`  in  DATA_W  combinational read from `dmem`

## Operation
- Grant is combinational from the inputs and `starve_cnt`:
  - `force = dma_valid && cpu_req && starve_cnt == STARVE_MAX`.
  - Grant DMA if `dma_valid && (!cpu_req || force)`. Otherwise grant CPU.
- Grant CPU: `mem_*` = core fields. `mem_we = cpu_req && cpu_we`. `mem_web = cpu_web` when `mem_we`, else 0.
- Grant DMA: `mem_*` = DMA fields. `mem_we = dma_we`. `dma_ready = 1`.
- `cpu_stall = force`. A stalled core store must not reach memory. The core re-presents it next cycle.
- Idle (no `cpu_req`, no `dma_valid`): `mem_addr = cpu_addr`, `mem_we = 0`, `mem_web = 0`.
- `starve_cnt` (4 bits):
  - Cleared on any DMA grant or when `!dma_valid`.
  - Incremented when `dma_valid && cpu_req && !force`.
  - Never exceeds `STARVE_MAX`.
- Accepted DMA read (`dma_ready && !dma_we`): `dma_rdata <= mem_rdata`, `dma_rvalid <= 1` next edge. Otherwise `dma_rvalid <= 0` and `dma_rdata` holds.
- DMA handshake: the request fields must stay stable while `dma_valid && !dma_ready`. Dropping `dma_valid` before acceptance is legal and clears `starve_cnt`.
- Reset (`reset == 0`):
  - Registered state: `starve_cnt = 0`, `dma_rvalid = 0`, `dma_rdata = 0`.
  - Combinational outputs are forced for the whole reset cycle: `dma_ready = 0`, `cpu_stall = 0`, `mem_we = 0`, `mem_web = 0`.
  - Reset mid-wait drops the pending DMA grant. The DMA must re-request.

## Timing
- Core access latency: 0 cycles (same-cycle read data, write on the next edge).
- DMA write: committed at the edge that ends the `dma_ready` cycle.
- DMA read: `dma_rvalid` one cycle after the `dma_ready` cycle.
- Worst-case DMA wait under continuous `cpu_req`: `STARVE_MAX` cycles, then granted on cycle `STARVE_MAX+1`.
- Core stalls: at most 1 cycle per `STARVE_MAX+1` cycles of contention.
- Back-to-back DMA requests with the core idle: accepted every cycle.

## Structure
- Package `dmem_arb_pkg`:
  - `typedef enum logic {GNT_CPU, GNT_DMA} grant_t`
  - `localparam STARVE_W = 4`
- One sub-module, `starve_ctr`: saturating counter with clear, increment and `at_max` outputs, parameterised by `STARVE_MAX`.
- The grant mux and read register stay in `dmem_arbiter`.

## Test plan
- Reset held 2 cycles with `dma_valid=1`, `cpu_req=1`, `cpu_we=1` -> `mem_we=0`, `dma_ready=0`, `cpu_stall=0`, `dma_rvalid=0` throughout. After release the core owns the port.
- Core idle, DMA write `addr=0x40`, `wdata=0xDEADBEEF`, `web=4'b1111` -> `dma_ready=1` same cycle. A following core load from `0x40` returns `0xDEADBEEF`.
- Continuous `cpu_req` plus `dma_valid`, `STARVE_MAX=4` -> `dma_ready` low cycles 1-4 and high on cycle 5 with `cpu_stall=1`. The core store in cycle 5 is not written, and its retry in cycle 6 is written.
- DMA read of `0x80` (preloaded `0x12345678`) with the core idle -> `dma_rvalid=1` and `dma_rdata=0x12345678` exactly one cycle after `dma_ready`. `dma_rvalid` is 0 on the following cycle.
- `dma_valid` dropped after 3 denied cycles, then reasserted -> the counter restarts, and the forced grant occurs 4 denied cycles later, not 1.
- Core store with `cpu_web=4'b0010` to `0x10` (preloaded `0xAABBCCDD`), `cpu_wdata=0x00001100` -> memory reads back `0xAABB11DD`. `dma_ready=0` that cycle.
